// File: rtl/trace_pkg.sv
// Shared types and constants for the architectural state trace dumper.
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_CHK  = 3'd3,
    ST_EMIT = 3'd4,
    ST_SEP  = 3'd5
  } state_e;

  // Special tags sit just above the register index range: tag = NUM_REGS + offset.
  localparam int unsigned TAG_HDR_OFS = 0;
  localparam int unsigned TAG_SEP_OFS = 1;

  localparam int unsigned DROP_W = 16;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the last dumped register values, with per-entry valid bits.
module shadow_regfile #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [XLEN-1:0] o_rdata_c,
  output logic            o_rvalid_c
);

  logic [XLEN-1:0]     r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_vld;

  // Data array carries no reset; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (i_we) begin
      r_vld[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata_c  = r_mem[i_raddr];
  assign o_rvalid_c = r_vld[i_raddr];

endmodule

// File: rtl/state_trace_dumper.sv
// Streams a PC header, full or changed-only register values, and a count
// separator each time the processor signals entry to its fetch state.
module state_trace_dumper
  import trace_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned TAGW     = $clog2(NUM_REGS + 2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trigger,
  input  logic [XLEN-1:0]             pc_in,
  input  logic                        mode,
  output logic [$clog2(NUM_REGS)-1:0] rf_raddr,
  input  logic [XLEN-1:0]             rf_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAGW-1:0]             out_tag,
  output logic [XLEN-1:0]             out_data,
  output logic                        busy,
  output logic [15:0]                 dropped_cnt
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam int unsigned CW = $clog2(NUM_REGS + 1);
  localparam logic [TAGW-1:0] TAG_HDR = TAGW'(NUM_REGS + TAG_HDR_OFS);
  localparam logic [TAGW-1:0] TAG_SEP = TAGW'(NUM_REGS + TAG_SEP_OFS);

  state_e          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_mode;
  logic            r_valid, w_valid_nxt;
  logic [TAGW-1:0] r_tag, w_tag_nxt;
  logic [XLEN-1:0] r_data, w_data_nxt;
  logic            r_busy;
  logic [15:0]     r_dropped;

  logic            w_xfer;
  logic            w_last;
  logic            w_changed;
  logic            w_sh_we;
  logic [XLEN-1:0] w_sh_rdata;
  logic            w_sh_rvalid;

  assign w_xfer    = r_valid & out_ready;
  assign w_last    = (r_idx == IW'(NUM_REGS - 1));
  assign w_changed = ~r_mode | ~w_sh_rvalid | (w_sh_rdata != rf_rdata);

  shadow_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .AW       (IW)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_sh_we),
    .i_waddr    (r_idx),
    .i_wdata    (r_data),
    .i_raddr    (r_idx),
    .o_rdata_c  (w_sh_rdata),
    .o_rvalid_c (w_sh_rvalid)
  );

  // Next-state and next-record selection; the record registers only change
  // on a state change, so a stalled record holds by construction.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_tag_nxt   = r_tag;
    w_data_nxt  = r_data;
    w_sh_we     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (trigger) begin
          w_state_nxt = ST_HDR;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_tag_nxt   = TAG_HDR;
          w_data_nxt  = pc_in;
        end
      end
      ST_HDR: begin
        if (w_xfer) w_state_nxt = ST_RD;
      end
      ST_RD: begin
        w_state_nxt = ST_CHK;
      end
      ST_CHK: begin
        if (w_changed) begin
          w_state_nxt = ST_EMIT;
          w_tag_nxt   = TAGW'(r_idx);
          w_data_nxt  = rf_rdata;
        end else if (w_last) begin
          w_state_nxt = ST_SEP;
          w_tag_nxt   = TAG_SEP;
          w_data_nxt  = XLEN'(r_cnt);
        end else begin
          w_state_nxt = ST_RD;
          w_idx_nxt   = r_idx + IW'(1);
        end
      end
      ST_EMIT: begin
        if (w_xfer) begin
          w_sh_we   = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_last) begin
            w_state_nxt = ST_SEP;
            w_tag_nxt   = TAG_SEP;
            w_data_nxt  = XLEN'(r_cnt + CW'(1));
          end else begin
            w_state_nxt = ST_RD;
            w_idx_nxt   = r_idx + IW'(1);
          end
        end
      end
      ST_SEP: begin
        if (w_xfer) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_valid_nxt = (w_state_nxt == ST_HDR) || (w_state_nxt == ST_EMIT) ||
                  (w_state_nxt == ST_SEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_tag   <= w_tag_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_IDLE && trigger) r_mode <= mode;
    end
  end

  // Any trigger outside IDLE is lost, including one on the final SEP transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropped <= '0;
    end else if (trigger && r_state != ST_IDLE) begin
      r_dropped <= sat_inc(r_dropped);
    end
  end

  assign rf_raddr    = r_idx;
  assign out_valid   = r_valid;
  assign out_tag     = r_tag;
  assign out_data    = r_data;
  assign busy        = r_busy;
  assign dropped_cnt = r_dropped;

endmodule

// File: tb/tb_state_trace_dumper.sv
// Directed and randomized dumps compared against a queue-based record model.
module tb_state_trace_dumper;

  localparam int unsigned NR   = 32;
  localparam int unsigned TAGW = 6;
  localparam logic [TAGW-1:0] T_HDR = TAGW'(NR);
  localparam logic [TAGW-1:0] T_SEP = TAGW'(NR + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [31:0] pc_in;
  logic        mode;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_tag;
  logic [31:0] out_data;
  logic        busy;
  logic [15:0] dropped_cnt;

  always #5 clk = ~clk;

  state_trace_dumper #(.XLEN(32), .NUM_REGS(NR), .TAGW(TAGW)) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .pc_in       (pc_in),
    .mode        (mode),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_tag     (out_tag),
    .out_data    (out_data),
    .busy        (busy),
    .dropped_cnt (dropped_cnt)
  );

  // Register file with one cycle of read latency
  logic [31:0] rf [NR];
  always @(posedge clk) rf_rdata <= rf[rf_raddr];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [37:0] obs_q [$];
  logic [37:0] exp_q [$];
  bit          sh_v [NR];
  logic [31:0] sh_d [NR];
  int          ready_mode;
  bit          sep_trig;
  bit          prev_stall;
  logic [5:0]  prev_tag;
  logic [31:0] prev_data;
  int          n_stall_bad;
  int          busy_cycles;
  int          exp_dropped;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: check stall hold, drive inputs at negedge, log pending transfer.
  task automatic tick(input logic trg);
    @(negedge clk);
    if (prev_stall && !(out_valid === 1'b1 && out_tag === prev_tag && out_data === prev_data))
      n_stall_bad++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    trigger = trg;
    if (sep_trig && out_valid && out_ready && out_tag == T_SEP) trigger = 1'b1;
    if (out_valid && out_ready) obs_q.push_back({out_tag, out_data});
    prev_stall = out_valid && !out_ready;
    prev_tag   = out_tag;
    prev_data  = out_data;
    if (busy) busy_cycles++;
  endtask

  // Records the dump must produce, from the shadow rules on the model state.
  task automatic build_expected(input logic md, input logic [31:0] pc, output int emitted);
    exp_q.delete();
    exp_q.push_back({T_HDR, pc});
    emitted = 0;
    for (int i = 0; i < NR; i++) begin
      if (!md || !sh_v[i] || sh_d[i] != rf[i]) begin
        exp_q.push_back({6'(i), rf[i]});
        sh_v[i] = 1'b1;
        sh_d[i] = rf[i];
        emitted++;
      end
    end
    exp_q.push_back({T_SEP, 32'(emitted)});
  endtask

  task automatic run_dump(input string name, input logic md, input logic [31:0] pc,
                          input bit mid_trig, input int abort_at);
    int  emitted;
    bit  done;
    bit  aborted;
    int  n;
    build_expected(md, pc, emitted);
    obs_q.delete();
    busy_cycles = 0;
    n_stall_bad = 0;
    prev_stall  = 1'b0;
    mode        = md;
    pc_in       = pc;
    tick(1'b1);
    done    = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      tick(mid_trig && (k == 5 || k == 20 || k == 50));
      if (abort_at > 0 && obs_q.size() == abort_at) begin
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        check({name, "_valid_after_rst"}, 64'(out_valid), 64'(0));
        check({name, "_busy_after_rst"}, 64'(busy), 64'(0));
        check({name, "_dropped_after_rst"}, 64'(dropped_cnt), 64'(0));
        aborted = 1'b1;
        done    = 1'b1;
      end else if (!busy && !out_valid) begin
        done = 1'b1;
      end
    end
    if (!done) check({name, "_timeout"}, 64'(1), 64'(0));
    if (!aborted) begin
      check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({name, "_rec"}, 64'(obs_q[i]), 64'(exp_q[i]));
      check({name, "_stall_hold"}, 64'(n_stall_bad), 64'(0));
      if (ready_mode == 0)
        check({name, "_cycles"}, 64'(busy_cycles), 64'(2 + 3 * emitted + 2 * (NR - emitted)));
    end
  endtask

  initial begin
    int          nch;
    int          idx;
    logic        md;
    rst         = 1'b1;
    trigger     = 1'b0;
    mode        = 1'b0;
    pc_in       = '0;
    out_ready   = 1'b1;
    ready_mode  = 0;
    sep_trig    = 1'b0;
    exp_dropped = 0;
    for (int i = 0; i < NR; i++) begin
      rf[i]   = 32'(i * 4);
      sh_v[i] = 1'b0;
      sh_d[i] = '0;
    end
    repeat (3) tick(1'b0);
    rst = 1'b0;
    tick(1'b0);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_raddr", 64'(rf_raddr), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_dropped", 64'(dropped_cnt), 64'(0));

    run_dump("full", 1'b0, 32'h0000_0040, 1'b0, 0);
    check("full_busy_end", 64'(busy), 64'(0));

    rf[5] = 32'hDEAD_BEEF;
    run_dump("delta_x5", 1'b1, 32'h0000_0044, 1'b0, 0);

    run_dump("delta_nochg", 1'b1, 32'h0000_0048, 1'b0, 0);
    run_dump("delta_nochg2", 1'b1, 32'h0000_004C, 1'b0, 0);
    check("nochg_len", 64'(obs_q.size()), 64'(2));

    ready_mode = 1;
    run_dump("full_bp", 1'b0, 32'h0000_0040, 1'b0, 0);
    ready_mode = 0;

    sep_trig = 1'b1;
    run_dump("drop", 1'b0, 32'h0000_1000, 1'b1, 0);
    sep_trig = 1'b0;
    exp_dropped += 4;
    repeat (5) tick(1'b0);
    check("drop_no_restart", 64'(busy), 64'(0));
    check("drop_cnt", 64'(dropped_cnt), 64'(exp_dropped));

    run_dump("abort", 1'b0, 32'h0000_2000, 1'b0, 10);
    for (int i = 0; i < NR; i++) sh_v[i] = 1'b0;
    exp_dropped = 0;
    run_dump("delta_after_rst", 1'b1, 32'h0000_3000, 1'b0, 0);
    check("after_rst_len", 64'(obs_q.size()), 64'(NR + 2));

    for (int it = 0; it < 8; it++) begin
      ready_mode = (it % 2 == 0) ? 0 : 2;
      nch = $urandom_range(0, 4);
      for (int c = 0; c < nch; c++) begin
        idx = $urandom_range(0, NR - 1);
        if ($urandom_range(0, 3) != 0) rf[idx] = $urandom;
      end
      md = 1'($urandom_range(0, 3) != 0);
      run_dump("random", md, $urandom, 1'b0, 0);
    end
    check("final_dropped", 64'(dropped_cnt), 64'(exp_dropped));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/state_trace_dumper.md
STATE_TRACE_DUMPER -- requirements
Module: state_trace_dumper

Interface
REQ-001 Parameter XLEN, default 32, SHALL set PC and register data width.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the number of architectural registers dumped (2..64).
REQ-003 Parameter TAGW, default $clog2(NUM_REGS+2), SHALL set the record tag width.
REQ-004 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 trigger  input  1  SHALL be a one-cycle pulse requesting a dump (processor entering fetch state).
REQ-007 pc_in  input  XLEN  SHALL be the program counter, sampled on an accepted trigger.
REQ-008 mode  input  1  SHALL select the dump mode: 0 = full dump, 1 = delta dump; sampled on an accepted trigger.
REQ-009 rf_raddr  output  $clog2(NUM_REGS)  SHALL be the register-file read address.
REQ-010 rf_rdata  input  XLEN  SHALL be the read data, valid exactly one cycle after rf_raddr.
REQ-011 out_valid  output  1  SHALL flag a valid trace record.
REQ-012 out_ready  input  1  SHALL be the consumer ready signal; a record transfers when out_valid && out_ready.
REQ-013 out_tag  output  TAGW  SHALL carry 0..NUM_REGS-1 = register index, NUM_REGS = PC header, NUM_REGS+1 = separator.
REQ-014 out_data  output  XLEN  SHALL carry the record payload.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-016 dropped_cnt  output  16  SHALL count triggers rejected while busy, saturating at 16'hFFFF.

Function
REQ-017 FSM states SHALL be IDLE, HDR, RD, CHK, EMIT, SEP.
REQ-018 IDLE: trigger SHALL latch pc_in and mode, clear the emitted-count and index, and go to HDR; busy rises the next cycle.
REQ-019 HDR: out_valid=1, tag=NUM_REGS, data=latched PC; on transfer, go to RD.
REQ-020 RD: drive rf_raddr=index for one cycle, then go to CHK.
REQ-021 CHK: sample rf_rdata; in full mode, or if the shadow entry is invalid or differs from rf_rdata, go to EMIT; otherwise skip the register.
REQ-022 EMIT: out_valid=1, tag=index, data=sampled value; on transfer, write the value to shadow[index], set its valid bit, and increment the emitted-count.
REQ-023 After CHK-skip or EMIT transfer: if index==NUM_REGS-1, go to SEP; else increment index and go to RD.
REQ-024 SEP: out_valid=1, tag=NUM_REGS+1, data=emitted-count zero-extended to XLEN; on transfer, go to IDLE.
REQ-025 While out_valid=1 and out_ready=0, out_tag and out_data SHALL hold stable and the FSM SHALL not advance.
REQ-026 out_valid SHALL be 0 in IDLE, RD and CHK.
REQ-027 A trigger in any state other than IDLE SHALL be ignored and SHALL increment dropped_cnt. This includes the SEP cycle in which the final transfer occurs.
REQ-028 A full dump SHALL last NUM_REGS+2 transfers.
REQ-029 A delta dump in which no register has changed SHALL be exactly two transfers: the header, then a separator with data=0.
REQ-030 Full-mode dumps SHALL also refresh the shadow, so a following delta dump reports only changes since that dump.
REQ-031 Register 0 SHALL be treated like every other index. No hardwired-zero special case applies.
REQ-032 With out_ready held high, each emitted register SHALL take 3 cycles (RD, CHK, EMIT) and each skipped register 2 cycles.

Reset
REQ-033 On rst, the FSM SHALL go to IDLE and out_valid, busy, rf_raddr, out_tag, out_data, dropped_cnt and the emitted-count SHALL all be 0.
REQ-034 On rst, all shadow valid bits SHALL clear; shadow data need not be reset.
REQ-035 rst asserted mid-dump SHALL abort the dump with no separator. out_valid SHALL be 0 on the cycle after rst, and the first delta dump after reset SHALL emit all registers.
REQ-036 rst SHALL take priority over a simultaneous trigger.

Structure
REQ-037 The package trace_pkg SHALL hold the FSM state enum and the tag encoding constants (TAG_HDR, TAG_SEP offsets).
REQ-038 The shadow storage (NUM_REGS x XLEN data plus NUM_REGS valid bits, one write port, one read port) SHALL be the sub-module shadow_regfile.
REQ-039 Everything else SHALL be in state_trace_dumper.

Verification
REQ-040 Full dump: rst, then trigger with pc_in=32'h0000_0040, mode=0, out_ready=1, rf x[i]=i*4 -> 34 records: header data 32'h40, registers 0..31 with data i*4, separator data 32; busy low after the separator.
REQ-041 Delta after full dump: modify only x5=32'hDEAD_BEEF, then trigger with mode=1 -> header, then tag 5 with data DEADBEEF, then separator with data 1.
REQ-042 Backpressure: out_ready toggled 0/1 every cycle during a full dump -> no record lost or duplicated, payload stable while stalled, same 34 records as REQ-040.
REQ-043 Trigger while busy: 3 triggers issued during a dump, plus 1 on the final SEP transfer cycle -> dropped_cnt=4 and no extra dump starts.
REQ-044 Reset mid-dump: rst at the 10th transfer -> out_valid=0 the next cycle and dropped_cnt=0; a subsequent delta trigger emits all 32 registers (separator data 32).
REQ-045 Unchanged delta: two consecutive mode=1 triggers with no register writes -> the second dump is header + separator (data 0) only.
